// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 field bundles into 32-bit instruction words, tags each word
// with a byte address and queues it in a small FIFO for the IMEM loader.
// Optional build macro: ENC_STRICT_EN adds funct-field legality checks on top of the
// opcode check.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 op,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 rd,
  input  logic [11:0]                imm12,
  input  logic [19:0]                immhi,
  input  logic                       addr_load,
  input  logic [ADDR_W-1:0]          addr_base,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       err_illegal,
  output logic [7:0]                 illegal_cnt,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic              s1_valid_q;
  logic [6:0]        s1_op_q;
  logic [2:0]        s1_funct3_q;
  logic [6:0]        s1_funct7_q;
  logic [4:0]        s1_rs1_q;
  logic [4:0]        s1_rs2_q;
  logic [4:0]        s1_rd_q;
  logic [11:0]       s1_imm12_q;
  logic [19:0]       s1_immhi_q;

  logic [31:0]       enc_word;
  logic              s1_illegal;
  logic              fifo_full;
  logic              adv;
  logic              push;
  logic              pop;

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] wr_tag;

  logic              err_q;
  logic [7:0]        ill_cnt_q;

  // Handshake: an illegal bundle always drains; a legal one needs FIFO room (no pop bypass).
  always_comb begin
    fifo_full = (count_q == CntW'(DEPTH));
    adv       = s1_valid_q && (s1_illegal || !fifo_full);
    push      = adv && !s1_illegal;
    pop       = (count_q != '0) && out_ready;
    in_ready  = !s1_valid_q || adv;
  end

  // S1 register: captures the bundle on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q     <= op;
        s1_funct3_q <= funct3;
        s1_funct7_q <= funct7;
        s1_rs1_q    <= rs1;
        s1_rs2_q    <= rs2;
        s1_rd_q     <= rd;
        s1_imm12_q  <= imm12;
        s1_immhi_q  <= immhi;
      end
    end
  end

  // Format encoder and legality check on the S1 bundle.
  always_comb begin
    enc_word   = '0;
    s1_illegal = 1'b0;
    case (s1_op_q)
      7'b0110011, 7'b1010011:
        enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_op_q};
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0000111:
        enc_word = {s1_imm12_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_op_q};
      7'b0100011, 7'b0100111:
        enc_word = {s1_imm12_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm12_q[4:0], s1_op_q};
      7'b1100011:
        // imm12 carries offset[12:1]
        enc_word = {s1_imm12_q[11], s1_imm12_q[9:4], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                    s1_imm12_q[3:0], s1_imm12_q[10], s1_op_q};
      7'b0010111, 7'b0110111, 7'b1101111:
        enc_word = {s1_immhi_q, s1_rd_q, s1_op_q};
      default:
        s1_illegal = 1'b1;
    endcase
`ifdef ENC_STRICT_EN
    if (s1_op_q == 7'b0110011 && !(s1_funct7_q inside {7'b0000000, 7'b0100000, 7'b0000001})) begin
      s1_illegal = 1'b1;
    end
    if (s1_op_q == 7'b0010011 && s1_funct3_q == 3'b001 && s1_imm12_q[11:5] != 7'b0000000) begin
      s1_illegal = 1'b1;
    end
    if (s1_op_q == 7'b0010011 && s1_funct3_q == 3'b101 &&
        !(s1_imm12_q[11:5] inside {7'b0000000, 7'b0100000})) begin
      s1_illegal = 1'b1;
    end
    if (s1_op_q == 7'b1100111 && s1_funct3_q != 3'b000) begin
      s1_illegal = 1'b1;
    end
`endif
  end

  // Address tag for the word being written; a same-cycle load overrides the pointer.
  always_comb begin
    base_aligned = addr_base & ~ADDR_W'(3);
    wr_tag       = addr_load ? base_aligned : ptr_q;
  end

  // Address pointer: advances by one word per legal write, or reloads from the base.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (push) begin
      ptr_q <= wr_tag + ADDR_W'(4);
    end else if (addr_load) begin
      ptr_q <= base_aligned;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= enc_word;
      mem_addr[wr_ptr_q]  <= wr_tag;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Illegal-bundle pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      err_q <= adv && s1_illegal;
      if (adv && s1_illegal && ill_cnt_q != 8'hFF) begin
        ill_cnt_q <= ill_cnt_q + 8'd1;
      end
    end
  end

  // Output drive: head entry when non-empty, zero otherwise.
  always_comb begin
    out_valid   = (count_q != '0);
    out_instr   = out_valid ? mem_instr[rd_ptr_q] : '0;
    out_addr    = out_valid ? mem_addr[rd_ptr_q] : '0;
    fifo_count  = count_q;
    err_illegal = err_q;
    illegal_cnt = ill_cnt_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed bundles, a queue-based reference model
// of expected {word, address} pairs, and a pop-side compare process.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic [11:0]   imm12;
  logic [19:0]   immhi;
  logic          addr_load;
  logic [AW-1:0] addr_base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err_illegal;
  logic [7:0]    illegal_cnt;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm12(imm12),
    .immhi(immhi), .addr_load(addr_load), .addr_base(addr_base), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] mptr;
  int            mill;
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference encoding straight from the format table: {legal, word}.
  function automatic logic [32:0] model_enc(input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] r1,
                                            input logic [4:0] r2, input logic [4:0] rdd,
                                            input logic [11:0] i12, input logic [19:0] ih);
    logic [31:0] w;
    logic        ok;
    ok = 1'b1;
    w  = '0;
    case (o)
      7'h33, 7'h53:               w = {f7, r2, r1, f3, rdd, o};
      7'h03, 7'h13, 7'h67, 7'h07: w = {i12, r1, f3, rdd, o};
      7'h23, 7'h27:               w = {i12[11:5], r2, r1, f3, i12[4:0], o};
      7'h63:                      w = {i12[11], i12[9:4], r2, r1, f3, i12[3:0], i12[10], o};
      7'h17, 7'h37, 7'h6F:        w = {ih, rdd, o};
      default:                    ok = 1'b0;
    endcase
`ifdef ENC_STRICT_EN
    if (o == 7'h33 && !(f7 inside {7'h00, 7'h20, 7'h01})) ok = 1'b0;
    if (o == 7'h13 && f3 == 3'd1 && i12[11:5] != 7'h00) ok = 1'b0;
    if (o == 7'h13 && f3 == 3'd5 && !(i12[11:5] inside {7'h00, 7'h20})) ok = 1'b0;
    if (o == 7'h67 && f3 != 3'd0) ok = 1'b0;
`endif
    return {ok, w};
  endfunction

  // Present one bundle and hold it until accepted; model records it at acceptance.
  task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                      input logic [11:0] i12, input logic [19:0] ih);
    logic [32:0] e;
    ent_t        en;
    bit          done;
    in_valid = 1'b1; op = o; funct3 = f3; funct7 = f7;
    rs1 = r1; rs2 = r2; rd = rdd; imm12 = i12; immhi = ih;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        e = model_enc(o, f3, f7, r1, r2, rdd, i12, ih);
        if (e[32]) begin
          en.w = e[31:0];
          en.a = mptr;
          mq.push_back(en);
          mptr = mptr + AW'(4);
        end else if (mill < 255) begin
          mill++;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); mptr = '0; mill = 0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (!out_valid && mq.size() == 0) done = 1'b1;
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_model_empty", 32'(mq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Compare process: every word popped must match the model's next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (mq.size() == 0) begin
        checks++;
        $display("FAIL spurious_word: out_instr=0x%0h out_addr=0x%0h, required no word",
                 out_instr, out_addr);
      end else begin
        chk("pop_instr", out_instr, mq[0].w);
        chk("pop_addr", 32'(out_addr), 32'(mq[0].a));
        void'(mq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    op = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0;
    imm12 = '0; immhi = '0; addr_base = '0; out_ready = 1'b0;
    do_reset();

    // Pin the model against hand-encoded words.
    e = model_enc(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd5, 20'd0);
    chk("model_addi", e[31:0], 32'h00500093);
    e = model_enc(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0);
    chk("model_add", e[31:0], 32'h002081B3);
    e = model_enc(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 12'h004, 20'd0);
    chk("model_beq", e[31:0], 32'h00208463);
    e = model_enc(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 12'd12, 20'd0);
    chk("model_sw", e[31:0], 32'h0020A623);

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    @(posedge clk); #1;

    // 1: addi, latency and literal word/address
    send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd5, 20'd0);
    @(negedge clk);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", out_instr, 32'h00500093);
    chk("t1_addr", 32'(out_addr), 32'h000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // 2, 3: R add, B beq, S sw
    send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0);
    send(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 12'h004, 20'd0);
    send(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 12'd12, 20'd0);
    send(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 12'd0, 20'hABCDE);
    wait_drain();

    // 4: illegal opcode pulses err once, leaves the address alone
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0);
    @(negedge clk);
    chk("t4_err_before", 32'(err_illegal), 32'd0);
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_illegal), 32'd1);
    chk("t4_cnt", 32'(illegal_cnt), 32'(mill));
    chk("t4_no_write", 32'(fifo_count), 32'd0);
    @(negedge clk);
    chk("t4_err_after", 32'(err_illegal), 32'd0);
    @(posedge clk); #1;
    send(7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd0, 20'h12345);
    wait_drain();

    // addr_load in the same cycle as the write retags that word
    send(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd4, 12'd9, 20'd0);
    addr_load = 1'b1; addr_base = 8'h31;
    mq[mq.size()-1].a = 8'h30;
    mptr = 8'h34;
    @(posedge clk); #1;
    addr_load = 1'b0;
    send(7'h03, 3'd2, 7'd0, 5'd2, 5'd0, 5'd5, 12'd4, 20'd0);
    wait_drain();

    // 5: backpressure fills S1 + FIFO, then drains in order
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'(i + 1), 20'd0);
    in_valid = 1'b1; op = 7'h13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_in_ready_low", 32'(in_ready), 32'd0);
      chk("t5_count_full", 32'(fifo_count), 32'd4);
      chk("t5_head_stable", out_instr, 32'h00100093);
      chk("t5_head_addr", 32'(out_addr), 32'h000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // illegal counter saturates
    for (int i = 0; i < 260; i++) send(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0, 20'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt_model", 32'(illegal_cnt), 32'(mill));
    chk("sat_cnt_255", 32'(illegal_cnt), 32'd255);

    // 6: address wrap at 2^ADDR_W, then reset mid-stream
    do_reset();
    addr_load = 1'b1; addr_base = 8'hFE;
    @(posedge clk); #1;
    addr_load = 1'b0;
    mptr = 8'hFC;
    out_ready = 1'b1;
    send(7'h33, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 12'd0, 20'd0);
    send(7'h17, 3'd0, 7'd0, 5'd0, 5'd0, 5'd8, 12'd0, 20'h00001);
    wait_drain();
    out_ready = 1'b0;
    send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd1, 20'd0);
    send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd2, 20'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); mptr = '0; mill = 0;
    @(negedge clk);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd2, 12'd7, 20'd0);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
